fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the segmented-memory processor. It owns the program counter, drives the instruction-segment address of the memory, and captures each returned 24-bit instruction into the IF/ID pipeline register for decode. It handles the start handshake that releases the core, pipeline stalls, flushes, taken-branch redirects, and halting on a HALT opcode.

## Interface
- WIDTH, 36, PC / instruction-address width
- INSTRUCTIONWIDTH, 24, instruction word width
- RESET_PC, 0, first fetch address after reset or restart
- HALT_OPCODE, 4'hF, value of instruction bits [INSTRUCTIONWIDTH-1:INSTRUCTIONWIDTH-4] that halts fetch

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leaves IDLE/HALT and begins fetching at RESET_PC
- stall  in  1  hold PC and IF/ID register
- flush  in  1  squash IF/ID slot
- branch_taken  in  1  redirect fetch to branch_target
- branch_target  in  WIDTH  redirect address
- imem_addr  out  WIDTH  instruction-segment address to memory; equals PC
- imem_rdata  in  INSTRUCTIONWIDTH  instruction from memory; combinational read of imem_addr in the same cycle
- if_instr  out  INSTRUCTIONWIDTH  IF/ID instruction
- if_pc  out  WIDTH  address of if_instr
- if_pc_plus1  out  WIDTH  if_pc+1 mod 2^WIDTH
- if_valid  out  1  IF/ID slot holds a live instruction
- running  out  1  state == RUN
- halted  out  1  state == HALT

## Operation
- Reset, asynchronous: state IDLE, PC=RESET_PC, if_instr=0, if_pc=0, if_pc_plus1=0, if_valid=0. running=0, halted=0, perf counters 0.
- IDLE: PC held and IF/ID not written. start moves to RUN on the next edge with PC=RESET_PC.
- RUN: per edge, priority is branch_taken > flush > stall > normal.
  - branch_taken: PC<=branch_target and if_valid<=0. Applies even with stall or flush high.
  - flush: if_valid<=0 and PC held, so the current PC is refetched.
  - stall: PC and all IF/ID fields hold their values.
  - normal: if_instr<=imem_rdata, if_pc<=PC, if_pc_plus1<=PC+1, if_valid<=1, PC<=PC+1.
- PC arithmetic wraps modulo 2^WIDTH. At PC = all-ones, the next PC is 0.
- Halt: if a normal capture latches an instruction with opcode == HALT_OPCODE, the state goes to HALT on the same edge. That instruction remains valid in IF/ID, and PC stays at the HALT address +1.
- HALT: the first non-stalled edge sets if_valid<=0, after which IF/ID holds. PC is frozen. start restarts RUN at RESET_PC with if_valid<=0.
- start is ignored while in RUN. stall, flush, and branch inputs are ignored in IDLE and HALT.
- running and halted decode combinationally from state.

## Timing
- Fetch latency is 1 cycle. With imem_addr=p in cycle n of RUN and no stall, if_pc=p and if_valid=1 in cycle n+1.
- Start: start high in cycle 0 (IDLE) gives running=1 and imem_addr=RESET_PC in cycle 1. First if_valid=1 occurs in cycle 2.
- Branch: branch_taken in cycle n gives imem_addr=target and if_valid=0 in cycle n+1. In cycle n+2, if_pc=target.
- Branch penalty is one bubble. Stall adds zero-latency hold.
- Reset asserted mid-RUN clears outputs immediately, without waiting for a clock edge. Fetch resumes only after rst deasserts and start is asserted.

## Configuration
- FETCH_PERF_EN defined: adds two outputs.
  - perf_fetched (out, 32): increments on each edge that latches if_valid<=1.
  - perf_stalls (out, 32): increments on each RUN edge with stall=1 and branch_taken=0.
  - Both counters wrap at 2^32 and reset asynchronously to 0.
- FETCH_PERF_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset then start, memory words 0..3 = 24'h000001..24'h000004: if_pc 0,1,2,3 on cycles 2..5 with matching if_instr, if_valid=1, if_pc_plus1=if_pc+1.
- Stall held 3 cycles at PC=2: imem_addr stays 2, IF/ID holds if_pc=1 throughout. After release, if_pc=2 next cycle; perf_stalls=3 when FETCH_PERF_EN.
- branch_taken with target 36'h10, with stall also high: next cycle imem_addr=16 and if_valid=0. Following cycle if_pc=16.
- Word 5 = 24'hF00000 (HALT): if_pc=5 is valid, then halted=1 and if_valid=0 next cycle, imem_addr frozen at 6. start restarts with first fetch at 0.
- Preload PC near wrap by branching to 36'hFFFFFFFFF: next if_pc_plus1=0 and imem_addr=0. rst pulse mid-run zeros all outputs without a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction address and fills the IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_stage #(
  parameter int               WIDTH            = 36,
  parameter int               INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0] RESET_PC         = '0,
  parameter logic [3:0]       HALT_OPCODE      = 4'hF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        branch_taken,
  input  logic [WIDTH-1:0]            branch_target,
  output logic [WIDTH-1:0]            imem_addr,
  input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
  output logic [INSTRUCTIONWIDTH-1:0] if_instr,
  output logic [WIDTH-1:0]            if_pc,
  output logic [WIDTH-1:0]            if_pc_plus1,
  output logic                        if_valid,
  output logic                        running,
  output logic                        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                 perf_fetched,
  output logic [31:0]                 perf_stalls
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                        state, state_next;
  logic [WIDTH-1:0]              pc, pc_next;
  logic [INSTRUCTIONWIDTH-1:0]   instr_next;
  logic [WIDTH-1:0]              ifpc_next, plus1_next;
  logic                          valid_next;
  logic                          capture;
  logic                          stall_count;
  logic [WIDTH-1:0]              pc_inc;

  assign pc_inc    = pc + WIDTH'(1);
  assign imem_addr = pc;
  assign running   = (state == S_RUN);
  assign halted    = (state == S_HALT);

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    instr_next  = if_instr;
    ifpc_next   = if_pc;
    plus1_next  = if_pc_plus1;
    valid_next  = if_valid;
    capture     = 1'b0;
    stall_count = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          pc_next    = RESET_PC;
        end
      end
      S_RUN: begin
        stall_count = stall && !branch_taken;
        if (branch_taken) begin
          pc_next    = branch_target;
          valid_next = 1'b0;
        end else if (flush) begin
          valid_next = 1'b0;
        end else if (!stall) begin
          capture    = 1'b1;
          instr_next = imem_rdata;
          ifpc_next  = pc;
          plus1_next = pc_inc;
          valid_next = 1'b1;
          pc_next    = pc_inc;
          // The HALT word itself stays live in IF/ID for decode.
          if (imem_rdata[INSTRUCTIONWIDTH-1 -: 4] == HALT_OPCODE)
            state_next = S_HALT;
        end
      end
      S_HALT: begin
        if (start) begin
          state_next = S_RUN;
          pc_next    = RESET_PC;
          valid_next = 1'b0;
        end else if (!stall) begin
          valid_next = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus1 <= '0;
      if_valid    <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_instr    <= instr_next;
      if_pc       <= ifpc_next;
      if_pc_plus1 <= plus1_next;
      if_valid    <= valid_next;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (capture)     perf_fetched <= perf_fetched + 32'd1;
      if (stall_count) perf_stalls  <= perf_stalls + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = capture ^ stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: start, stall, branch, flush, halt/restart, PC wrap and async reset.
// Memory model: words 0..3 = 1..4, word 5 = HALT, others = {4'h1, addr[19:0]}.
module tb_fetch_stage;
  localparam int W  = 36;
  localparam int IW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
  logic [W-1:0]  branch_target = '0;
  logic [W-1:0]  imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] if_instr;
  logic [W-1:0]  if_pc, if_pc_plus1;
  logic          if_valid, running, halted;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_stalls;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_word(input logic [W-1:0] a);
    if (a <= 36'd3)       return IW'(a + 36'd1);
    else if (a == 36'd5)  return 24'hF00000;
    else                  return {4'h1, a[19:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1),
    .if_valid(if_valid), .running(running), .halted(halted)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_valid", 64'(if_valid), 64'd0);
    check("rst_instr", 64'(if_instr), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    rst = 1'b0;

    // Start handshake
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_running", 64'(running), 64'd1);
    check("start_addr", 64'(imem_addr), 64'd0);
    check("start_valid", 64'(if_valid), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("seq_pc", 64'(if_pc), 64'(i));
      check("seq_instr", 64'(if_instr), 64'(i + 1));
      check("seq_plus1", 64'(if_pc_plus1), 64'(i + 1));
      check("seq_valid", 64'(if_valid), 64'd1);
    end

    // Stall three cycles at PC=2
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", 64'(imem_addr), 64'd2);
      check("stall_ifpc", 64'(if_pc), 64'd1);
      check("stall_valid", 64'(if_valid), 64'd1);
    end
    stall = 1'b0;
    step();
    check("unstall_pc", 64'(if_pc), 64'd2);
    check("unstall_instr", 64'(if_instr), 64'd3);
`ifdef FETCH_PERF_EN
    check("perf_stalls", 64'(perf_stalls), 64'd3);
`endif
    step();
    check("pc3", 64'(if_pc), 64'd3);
    check("instr3", 64'(if_instr), 64'd4);

    // Branch with stall also high
    branch_taken = 1'b1; branch_target = 36'h10; stall = 1'b1;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    check("br_addr", 64'(imem_addr), 64'h10);
    check("br_valid", 64'(if_valid), 64'd0);
    step();
    check("br_ifpc", 64'(if_pc), 64'h10);
    check("br_instr", 64'(if_instr), 64'h100010);
    check("br_valid2", 64'(if_valid), 64'd1);

    // Flush refetches the current PC
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 64'(if_valid), 64'd0);
    check("flush_addr", 64'(imem_addr), 64'h11);
    step();
    check("flush_refetch", 64'(if_pc), 64'h11);

    // Halt on word 5
    branch_taken = 1'b1; branch_target = 36'd5;
    step();
    branch_taken = 1'b0;
    step();
    check("halt_ifpc", 64'(if_pc), 64'd5);
    check("halt_instr", 64'(if_instr), 64'hF00000);
    check("halt_valid", 64'(if_valid), 64'd1);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_running", 64'(running), 64'd0);
    check("halt_addr", 64'(imem_addr), 64'd6);
    step();
    check("halt_valid2", 64'(if_valid), 64'd0);
    check("halt_addr2", 64'(imem_addr), 64'd6);
    branch_taken = 1'b1; branch_target = 36'h10;
    step();
    branch_taken = 1'b0;
    check("halt_br_ignored", 64'(imem_addr), 64'd6);

    // Restart from HALT
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_running", 64'(running), 64'd1);
    check("restart_addr", 64'(imem_addr), 64'd0);
    check("restart_valid", 64'(if_valid), 64'd0);
    step();
    check("restart_ifpc", 64'(if_pc), 64'd0);
    check("restart_instr", 64'(if_instr), 64'd1);
`ifdef FETCH_PERF_EN
    check("perf_fetched", 64'(perf_fetched), 64'd8);
`endif

    // PC wrap
    branch_taken = 1'b1; branch_target = 36'hFFFFFFFFF;
    step();
    branch_taken = 1'b0;
    check("wrap_addr_pre", 64'(imem_addr), 64'hFFFFFFFFF);
    step();
    check("wrap_ifpc", 64'(if_pc), 64'hFFFFFFFFF);
    check("wrap_plus1", 64'(if_pc_plus1), 64'd0);
    check("wrap_addr", 64'(imem_addr), 64'd0);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(if_valid), 64'd0);
    check("arst_ifpc", 64'(if_pc), 64'd0);
    check("arst_plus1", 64'(if_pc_plus1), 64'd0);
    check("arst_instr", 64'(if_instr), 64'd0);
    check("arst_running", 64'(running), 64'd0);
    check("arst_addr", 64'(imem_addr), 64'd0);
    rst = 1'b0;
    step();
    step();
    check("post_rst_idle", 64'(running), 64'd0);
    check("post_rst_valid", 64'(if_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
